muldiv_seq_ctrl: RTL and testbench

MULDIV_SEQ_CTRL -- requirements
Module: muldiv_seq_ctrl

---
 rtl/muldiv_seq_ctrl_if.sv | 37 +++
 rtl/muldiv_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_muldiv_seq_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_ctrl_if.sv
// Pipeline <-> multiply/divide sequencing controller signal bundle.
// master: EXE/ID pipeline side; slave: muldiv_seq_ctrl.
interface muldiv_seq_ctrl_if;
    localparam int unsigned CNT_W = 6;

    logic             i_EXE_valid;
    logic             i_EXE_is_div;
    logic             i_EXE_is_mult;
    logic             i_ID_reads_hilo;
    logic             i_flush;
    logic             i_pipe_hold;
    logic             i_divisor_is_zero;
    logic             i_dividend_lt_divisor;

    logic             o_div_start;
    logic             o_div_step;
    logic             o_div_done;
    logic             o_div_early;
    logic             o_exe_stall;
    logic             o_id_stall;
    logic [CNT_W-1:0] o_div_count;
    logic             o_busy;

    modport master (
        output i_EXE_valid, i_EXE_is_div, i_EXE_is_mult, i_ID_reads_hilo,
               i_flush, i_pipe_hold, i_divisor_is_zero, i_dividend_lt_divisor,
        input  o_div_start, o_div_step, o_div_done, o_div_early,
               o_exe_stall, o_id_stall, o_div_count, o_busy
    );

    modport slave (
        input  i_EXE_valid, i_EXE_is_div, i_EXE_is_mult, i_ID_reads_hilo,
               i_flush, i_pipe_hold, i_divisor_is_zero, i_dividend_lt_divisor,
        output o_div_start, o_div_step, o_div_done, o_div_early,
               o_exe_stall, o_id_stall, o_div_count, o_busy
    );
endinterface

// File: rtl/muldiv_seq_ctrl.sv
// Iterative divider sequencer and HI/LO hazard stall generator.
// Optional early exit (zero divisor / small dividend) enabled by YTTRIUM_DIV_EARLY_EXIT_EN.
module muldiv_seq_ctrl #(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic               clk,
    input  logic               resetn,
    muldiv_seq_ctrl_if.slave   bus
);
    localparam int unsigned CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             mult_mem_q, mult_mem_d;
    logic             early_q, early_d;

    logic             start_c;
    logic             early_hit_c;
    logic             div_start_c, div_step_c, div_done_c, exe_stall_c;
    logic             id_stall_c, busy_c, div_early_c;

`ifdef YTTRIUM_DIV_EARLY_EXIT_EN
    assign early_hit_c = bus.i_divisor_is_zero | bus.i_dividend_lt_divisor;
`else
    logic unused_early_inputs;
    assign unused_early_inputs = bus.i_divisor_is_zero ^ bus.i_dividend_lt_divisor;
    assign early_hit_c = 1'b0;
`endif

    assign start_c = bus.i_EXE_valid & bus.i_EXE_is_div & ~bus.i_flush;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            count_q    <= '0;
            mult_mem_q <= 1'b0;
            early_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            mult_mem_q <= mult_mem_d;
            early_q    <= early_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        early_d     = early_q;
        mult_mem_d  = 1'b0;
        div_start_c = 1'b0;
        div_step_c  = 1'b0;
        div_done_c  = 1'b0;
        exe_stall_c = 1'b0;
        id_stall_c  = 1'b0;
        busy_c      = (state_q != IDLE);
        div_early_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                count_d = '0;
                early_d = 1'b0;
                if (start_c) begin
                    div_start_c = 1'b1;
                    exe_stall_c = 1'b1;
                    if (early_hit_c) begin
                        state_d = DIV_DONE;
                        early_d = 1'b1;
                    end else begin
                        state_d = DIV_RUN;
                        count_d = CNT_W'(DIV_CYCLES - 1);
                    end
                end
            end
            DIV_RUN: begin
                div_step_c  = 1'b1;
                exe_stall_c = 1'b1;
                if (count_q == '0) begin
                    state_d = DIV_DONE;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            DIV_DONE: begin
                div_done_c  = 1'b1;
                div_early_c = early_q;
                if (!bus.i_pipe_hold) begin
                    state_d = IDLE;
                    early_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
                early_d = 1'b0;
            end
        endcase

        // Flush kills any operation in flight, including one starting now
        if (bus.i_flush) begin
            state_d     = IDLE;
            count_d     = '0;
            early_d     = 1'b0;
            div_start_c = 1'b0;
            div_step_c  = 1'b0;
            div_done_c  = 1'b0;
        end

        mult_mem_d = bus.i_EXE_valid & bus.i_EXE_is_mult & ~exe_stall_c
                   & ~bus.i_pipe_hold & ~bus.i_flush;

        id_stall_c = exe_stall_c
                   | (bus.i_ID_reads_hilo
                      & ((bus.i_EXE_valid & (bus.i_EXE_is_mult | bus.i_EXE_is_div))
                         | mult_mem_q | busy_c));

        // Outputs read zero while reset is asserted, regardless of inputs
        if (!resetn) begin
            div_start_c = 1'b0;
            div_step_c  = 1'b0;
            div_done_c  = 1'b0;
            div_early_c = 1'b0;
            exe_stall_c = 1'b0;
            id_stall_c  = 1'b0;
            busy_c      = 1'b0;
        end
    end

    assign bus.o_div_start = div_start_c;
    assign bus.o_div_step  = div_step_c;
    assign bus.o_div_done  = div_done_c;
    assign bus.o_div_early = div_early_c;
    assign bus.o_exe_stall = exe_stall_c;
    assign bus.o_id_stall  = id_stall_c;
    assign bus.o_div_count = count_q;
    assign bus.o_busy      = busy_c;
endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Directed testbench for muldiv_seq_ctrl: combinational decode table plus
// cycle-accurate divide, flush, hold, reset, mult-hazard and early-exit runs.
module tb_muldiv_seq_ctrl;
    logic clk;
    logic resetn;
    int   errors;
    int   checks;

`ifdef YTTRIUM_DIV_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    muldiv_seq_ctrl_if bus ();

    muldiv_seq_ctrl #(.DIV_CYCLES(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic valid, is_div, is_mult, reads, flush, hold;
        logic e_start, e_stall, e_id, e_busy;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int cyc, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.i_EXE_valid           = 1'b0;
        bus.i_EXE_is_div          = 1'b0;
        bus.i_EXE_is_mult         = 1'b0;
        bus.i_ID_reads_hilo       = 1'b0;
        bus.i_flush               = 1'b0;
        bus.i_pipe_hold           = 1'b0;
        bus.i_divisor_is_zero     = 1'b0;
        bus.i_dividend_lt_divisor = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    // Divide at cycle 10; optional hold through hold_hi, flush at flush_at, reset at rst_at.
    task automatic run_div(input int hold_hi, input int flush_at, input int rst_at, input string tag);
        int done_last;
        bit killed, v;
        do_reset();
        done_last = (hold_hi >= 43) ? hold_hi + 1 : 43;
        for (int c = 0; c <= 55; c++) begin
            @(posedge clk);
            #1;
            if (flush_at >= 0)    v = (c >= 10 && c <= flush_at);
            else if (rst_at >= 0) v = (c >= 10 && c <= rst_at);
            else                  v = (c >= 10 && c <= done_last);
            bus.i_EXE_valid  = v;
            bus.i_EXE_is_div = v;
            bus.i_flush      = (c == flush_at);
            bus.i_pipe_hold  = (c >= 43 && c <= hold_hi);
            if (rst_at >= 0 && c >= rst_at && c <= rst_at + 1) resetn = 1'b0;
            else resetn = 1'b1;
            #4;
            killed = (flush_at >= 0 && c > flush_at) || (rst_at >= 0 && c >= rst_at);
            if (killed) begin
                chk({tag, "_start"}, c, 8'(bus.o_div_start), 8'd0);
                chk({tag, "_step"},  c, 8'(bus.o_div_step),  8'd0);
                chk({tag, "_done"},  c, 8'(bus.o_div_done),  8'd0);
                chk({tag, "_stall"}, c, 8'(bus.o_exe_stall), 8'd0);
                chk({tag, "_id"},    c, 8'(bus.o_id_stall),  8'd0);
                chk({tag, "_busy"},  c, 8'(bus.o_busy),      8'd0);
                chk({tag, "_count"}, c, 8'(bus.o_div_count), 8'd0);
            end else begin
                chk({tag, "_start"}, c, 8'(bus.o_div_start), 8'(c == 10));
                chk({tag, "_step"},  c, 8'(bus.o_div_step),  8'(c >= 11 && c <= 42 && c != flush_at));
                chk({tag, "_done"},  c, 8'(bus.o_div_done),  8'(c >= 43 && c <= done_last));
                chk({tag, "_stall"}, c, 8'(bus.o_exe_stall), 8'(c >= 10 && c <= 42));
                chk({tag, "_id"},    c, 8'(bus.o_id_stall),  8'(c >= 10 && c <= 42));
                chk({tag, "_busy"},  c, 8'(bus.o_busy),      8'(c >= 11 && c <= done_last));
                chk({tag, "_count"}, c, 8'(bus.o_div_count), (c >= 11 && c <= 42) ? 8'(42 - c) : 8'd0);
            end
            chk({tag, "_early"}, c, 8'(bus.o_div_early), 8'd0);
        end
        clear_inputs();
        resetn = 1'b1;
    endtask

    // Divide by zero starting at cycle 3
    task automatic run_zero();
        int done_c;
        bit v;
        do_reset();
        done_c = EARLY ? 4 : 36;
        for (int c = 0; c <= 40; c++) begin
            @(posedge clk);
            #1;
            v = (c >= 3 && c <= done_c);
            bus.i_EXE_valid       = v;
            bus.i_EXE_is_div      = v;
            bus.i_divisor_is_zero = v;
            #4;
            chk("zero_done",  c, 8'(bus.o_div_done),  8'(c == done_c));
            chk("zero_step",  c, 8'(bus.o_div_step),  8'(!EARLY && c >= 4 && c <= 35));
            chk("zero_early", c, 8'(bus.o_div_early), 8'(EARLY && c == 4));
            chk("zero_stall", c, 8'(bus.o_exe_stall), EARLY ? 8'(c == 3) : 8'(c >= 3 && c <= 35));
        end
        clear_inputs();
    endtask

    // Mult in EXE at cycle 5 with MFLO in ID; bubble follows
    task automatic run_mult();
        do_reset();
        for (int c = 0; c <= 9; c++) begin
            @(posedge clk);
            #1;
            bus.i_EXE_valid     = (c == 5);
            bus.i_EXE_is_mult   = (c == 5);
            bus.i_ID_reads_hilo = (c >= 5 && c <= 7);
            #4;
            chk("mult_id",    c, 8'(bus.o_id_stall),  8'(c == 5 || c == 6));
            chk("mult_stall", c, 8'(bus.o_exe_stall), 8'd0);
        end
        clear_inputs();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        clear_inputs();
        resetn = 1'b0;

        //          valid div mult reads flush hold | start stall id busy
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset holds every output low even with a div and HI/LO reader present
        #3;
        bus.i_EXE_valid     = 1'b1;
        bus.i_EXE_is_div    = 1'b1;
        bus.i_ID_reads_hilo = 1'b1;
        #1;
        chk("rst_start", 0, 8'(bus.o_div_start), 8'd0);
        chk("rst_stall", 0, 8'(bus.o_exe_stall), 8'd0);
        chk("rst_id",    0, 8'(bus.o_id_stall),  8'd0);
        chk("rst_busy",  0, 8'(bus.o_busy),      8'd0);
        chk("rst_count", 0, 8'(bus.o_div_count), 8'd0);
        chk("rst_done",  0, 8'(bus.o_div_done),  8'd0);

        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            bus.i_EXE_valid     = vecs[i].valid;
            bus.i_EXE_is_div    = vecs[i].is_div;
            bus.i_EXE_is_mult   = vecs[i].is_mult;
            bus.i_ID_reads_hilo = vecs[i].reads;
            bus.i_flush         = vecs[i].flush;
            bus.i_pipe_hold     = vecs[i].hold;
            #4;
            chk("vec_start", i, 8'(bus.o_div_start), 8'(vecs[i].e_start));
            chk("vec_stall", i, 8'(bus.o_exe_stall), 8'(vecs[i].e_stall));
            chk("vec_id",    i, 8'(bus.o_id_stall),  8'(vecs[i].e_id));
            chk("vec_busy",  i, 8'(bus.o_busy),      8'(vecs[i].e_busy));
            @(posedge clk);
            #1;
            clear_inputs();
            bus.i_flush = 1'b1;
            @(posedge clk);
            #1;
            bus.i_flush = 1'b0;
        end
        clear_inputs();

        run_div(0, -1, -1, "div");
        run_div(45, -1, -1, "hold");
        run_div(0, 20, -1, "flush");
        run_div(0, -1, 25, "rstmid");
        run_mult();
        run_zero();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
